btn_loader: RTL and testbench
=============================

BTN_LOADER -- requirements
Module: btn_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES SHALL default to 500000; it is the stable-input cycle count required to accept a press or a release, and must be >= 2.
REQ-002 Parameter LOAD_HOLD SHALL default to 64; it is the number of cycles load_n is held low, sized to span at least one period of the downstream divided clock, and must be >= 1.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous reset, active-high.
REQ-006 btn  input  1  raw push-button, asynchronous, 1 = pressed.
REQ-007 sw  input  4  raw switch value, asynchronous.
REQ-008 value_o  output  4  latched switch value presented to the downstream shift register.
REQ-009 load_n  output  1  active-low load request to the downstream shift register.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 press_cnt  output  8  count of accepted presses.

Function
REQ-012 btn and sw SHALL each pass through a 2-flop synchronizer; only the synchronized versions (btn_s, sw_s) are used internally.
REQ-013 The FSM SHALL have exactly five states: IDLE, DEB_PRESS, LOAD, WAIT_REL, DEB_REL.
REQ-014 IDLE: if btn_s=1, go to DEB_PRESS and clear the counter; otherwise stay.
REQ-015 DEB_PRESS: if btn_s=0, go to IDLE (bounce rejected); if the counter = DEBOUNCE_CYCLES-1 and btn_s=1, go to LOAD, set value_o<=sw_s, increment press_cnt, and clear the counter; otherwise increment the counter.
REQ-016 LOAD: load_n SHALL be 0 for exactly LOAD_HOLD consecutive cycles, then the FSM goes to WAIT_REL; btn_s is ignored in this state.
REQ-017 WAIT_REL: if btn_s=0, go to DEB_REL and clear the counter.
REQ-018 DEB_REL: if btn_s=1, go to WAIT_REL; if the counter = DEBOUNCE_CYCLES-1 and btn_s=0, go to IDLE; otherwise increment the counter.
REQ-019 Latency: with btn held high and clean, load_n SHALL first read 0 after the (DEBOUNCE_CYCLES+3)th rising edge following the first edge that samples btn=1.
REQ-020 value_o SHALL change only on the DEB_PRESS->LOAD transition; sw changes at any other time SHALL NOT affect it.
REQ-021 load_n SHALL be 1 in every state other than LOAD; there SHALL be no glitch or extra low cycle.
REQ-022 press_cnt SHALL wrap from 255 to 0.
REQ-023 A held button SHALL produce exactly one load; a second load requires a debounced release followed by a debounced press.
REQ-024 The counter width SHALL be $clog2(DEBOUNCE_CYCLES) bits, and it SHALL saturate rather than wrap.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL enter IDLE and set value_o=0, load_n=1, busy=0, press_cnt=0, counters=0 and synchronizer flops=0, regardless of the current state, including mid-LOAD.
REQ-026 reset SHALL take priority over all FSM transitions in the same cycle.

Structure
REQ-027 Package btn_loader_pkg SHALL hold the state enum typedef and the default DEBOUNCE_CYCLES and LOAD_HOLD constants.
REQ-028 The block SHALL contain one sub-module, sync2, a parameterized-width 2-flop synchronizer with synchronous reset, instantiated for btn and sw.

Verification
REQ-029 The bench SHALL run with DEBOUNCE_CYCLES=4 and LOAD_HOLD=3, and SHALL cover these directed scenarios:
REQ-030 Clean press: sw=4'hA, btn=1 for 20 cycles -> load_n=0 for exactly 3 cycles, starting after the 7th edge; value_o=4'hA; press_cnt 0->1; busy=1 from edge 3.
REQ-031 Press bounce: btn=1 for 3 cycles, then 0 -> load_n never 0; press_cnt=0; FSM returns to IDLE.
REQ-032 Switch change during LOAD: sw=4'h3 at acceptance, then sw=4'h5 during LOAD -> value_o stays 4'h3 through the end of the test.
REQ-033 Release bounce: after a load, btn=0 for 2 cycles, back to 1 for 10 cycles, then 0 for 10 cycles -> only one load total; busy=0 only after the final debounce completes.
REQ-034 Reset mid-LOAD: reset=1 during the 2nd low cycle of load_n -> on the next edge load_n=1, value_o=0, press_cnt=0, busy=0.
REQ-035 Wrap: 256 clean press/release sequences -> press_cnt=0 and exactly 256 load pulses counted.

Source files
------------

// File: rtl/btn_loader_pkg.sv
// Shared state encoding and default timing constants for the button-driven loader.
package btn_loader_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned LOAD_HOLD_DEF       = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    LOAD      = 3'd2,
    WAIT_REL  = 3'd3,
    DEB_REL   = 3'd4
  } state_t;

endpackage

// File: rtl/btn_loader_sync2.sv
// Two-flop synchronizer of configurable width with synchronous reset.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_loader.sv
// Debounces a push-button and, once per accepted press, latches the switches
// and pulses load_n low for LOAD_HOLD cycles toward a downstream shift register.
module btn_loader
  import btn_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LOAD_HOLD       = LOAD_HOLD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic [3:0] sw,
  output logic [3:0] value_o,
  output logic       load_n,
  output logic       busy,
  output logic [7:0] press_cnt
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LOAD_HOLD - 1);

  logic          btn_s;
  logic [3:0]    sw_s;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;

  sync2 #(.W(1)) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (btn_s)
  );

  sync2 #(.W(4)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  assign busy = (state != IDLE);

  // load_n is registered and only driven low on entry to LOAD, so it cannot glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hold      <= '0;
      value_o   <= '0;
      load_n    <= 1'b1;
      press_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state     <= LOAD;
            value_o   <= sw_s;
            press_cnt <= press_cnt + 8'd1;
            cnt       <= '0;
            hold      <= '0;
            load_n    <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD: begin
          if (hold == HOLD_LAST) begin
            state  <= WAIT_REL;
            load_n <= 1'b1;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!btn_s) begin
            state <= DEB_REL;
            cnt   <= '0;
          end
        end
        DEB_REL: begin
          if (btn_s) begin
            state <= WAIT_REL;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          load_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_loader.sv
// Directed self-checking bench for btn_loader with DEBOUNCE_CYCLES=4, LOAD_HOLD=3.
module tb_btn_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [3:0] value_o;
  logic       load_n;
  logic       busy;
  logic [7:0] press_cnt;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned pulses = 0;
  int unsigned pulses0;
  logic        load_prev = 1'b1;

  btn_loader #(.DEBOUNCE_CYCLES(4), .LOAD_HOLD(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .sw        (sw),
    .value_o   (value_o),
    .load_n    (load_n),
    .busy      (busy),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  // Counts falling edges of load_n as seen at the sampling edge.
  always @(negedge clk) begin
    if (load_prev === 1'b1 && load_n === 1'b0) pulses = pulses + 1;
    load_prev = load_n;
  end

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn   = 1'b0;
    sw    = 4'h0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    step(1);
    do_reset();
    chk("rst_load_n", 32'(load_n), 32'd1);
    chk("rst_value", 32'(value_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(press_cnt), 32'd0);

    // Clean press: load_n low after edges 7..9, busy from edge 3.
    sw  = 4'hA;
    btn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      chk($sformatf("clean_load_n_e%0d", e), 32'(load_n), (e >= 7 && e <= 9) ? 32'd0 : 32'd1);
      chk($sformatf("clean_busy_e%0d", e), 32'(busy), (e >= 3) ? 32'd1 : 32'd0);
      if (e == 6) chk("clean_cnt_before", 32'(press_cnt), 32'd0);
      if (e == 7) begin
        chk("clean_cnt_after", 32'(press_cnt), 32'd1);
        chk("clean_value", 32'(value_o), 32'hA);
      end
    end
    btn = 1'b0;
    step(6);
    chk("clean_rel_busy_e6", 32'(busy), 32'd1);
    step(1);
    chk("clean_rel_busy_e7", 32'(busy), 32'd0);

    // Press bounce: DEB_PRESS entered at edge 3, bounce seen at edge 6.
    do_reset();
    btn = 1'b1;
    step(3);
    btn = 1'b0;
    step(2);
    chk("bounce_busy_e5", 32'(busy), 32'd1);
    step(1);
    chk("bounce_busy_e6", 32'(busy), 32'd0);
    pulses0 = pulses;
    step(6);
    chk("bounce_pulses", pulses - pulses0, 32'd0);
    chk("bounce_load_n", 32'(load_n), 32'd1);
    chk("bounce_cnt", 32'(press_cnt), 32'd0);
    chk("bounce_busy_end", 32'(busy), 32'd0);

    // Switch change during LOAD, then release bounce.
    do_reset();
    pulses0 = pulses;
    sw  = 4'h3;
    btn = 1'b1;
    step(7);
    chk("swchg_load_n_e7", 32'(load_n), 32'd0);
    chk("swchg_value_e7", 32'(value_o), 32'h3);
    sw = 4'h5;
    step(1);
    chk("swchg_load_n_e8", 32'(load_n), 32'd0);
    step(5);
    chk("swchg_load_n_e13", 32'(load_n), 32'd1);
    chk("swchg_value_e13", 32'(value_o), 32'h3);
    btn = 1'b0;
    step(2);
    btn = 1'b1;
    step(10);
    chk("relb_busy_mid", 32'(busy), 32'd1);
    chk("relb_load_n_mid", 32'(load_n), 32'd1);
    btn = 1'b0;
    step(6);
    chk("relb_busy_e6", 32'(busy), 32'd1);
    step(1);
    chk("relb_busy_e7", 32'(busy), 32'd0);
    step(3);
    chk("relb_pulses", pulses - pulses0, 32'd1);
    chk("relb_cnt", 32'(press_cnt), 32'd1);
    chk("swchg_value_end", 32'(value_o), 32'h3);

    // Reset asserted during the second low cycle of load_n.
    do_reset();
    sw  = 4'h9;
    btn = 1'b1;
    step(8);
    chk("midrst_load_n_before", 32'(load_n), 32'd0);
    chk("midrst_value_before", 32'(value_o), 32'h9);
    reset = 1'b1;
    btn   = 1'b0;
    step(1);
    chk("midrst_load_n", 32'(load_n), 32'd1);
    chk("midrst_value", 32'(value_o), 32'd0);
    chk("midrst_cnt", 32'(press_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step(3);

    // 256 clean press/release cycles wrap press_cnt back to zero.
    do_reset();
    pulses0 = pulses;
    for (int i = 0; i < 256; i++) begin
      sw  = 4'(i);
      btn = 1'b1;
      step(12);
      btn = 1'b0;
      step(9);
      if (i == 254) chk("wrap_cnt_255", 32'(press_cnt), 32'd255);
    end
    chk("wrap_cnt_0", 32'(press_cnt), 32'd0);
    chk("wrap_pulses", pulses - pulses0, 32'd256);
    chk("wrap_value", 32'(value_o), 32'hF);
    chk("wrap_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
